vend_change_fsm: RTL and testbench
==================================

Name: vend_change_fsm

Overview:
- Parametrised successor to the fixed-price, no-change vending controller.
- Price and credit ceiling are parameters. Credit is kept in a binary counter in 25-cent units, replacing the one-hot credit states.
- Adds a change-return sequence and a cancel/refund sequence.
- Sits between the coin acceptor, the dispenser actuator and the quarter-return hopper.

Parameters:
- PRICE_UNITS, 5, item price in 25-cent units (5 = $1.25); legal range 1..MAX_UNITS.
- MAX_UNITS, 12, maximum credit held, in 25-cent units (12 = $3.00).
- CW, $clog2(MAX_UNITS+1), width of the credit counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- coin  input  3  coin code sampled every cycle: 000 none, 001 quarter (1 unit), 010 fifty (2 units), 100 dollar (4 units); any other code is invalid.
- cancel  input  1  level, sampled every cycle; request refund of held credit.
- credit  output  CW  registered current credit, in units.
- busy  output  1  high in any state other than ACCEPT.
- dispense  output  1  one-cycle pulse; release one item.
- change_quarter  output  1  one pulse per quarter returned, whether change or refund.
- refunding  output  1  high while in REFUND.
- error  output  1  registered one-cycle pulse, asserted the cycle after a coin is rejected.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - Reset forces state=ACCEPT and credit=0; busy, dispense, change_quarter, refunding and error are all 0.
  - Reset has priority at any time, including mid-CHANGE or mid-REFUND. A partially returned sum is abandoned; no further pulses are issued.
- State machine, 4 states: ACCEPT, VEND, CHANGE, REFUND.
  - dispense, change_quarter, refunding and busy are Moore outputs decoded from the state register.
- ACCEPT:
  - cancel=1 and credit>0 -> REFUND. A coin in the same cycle is rejected; cancel wins.
  - cancel=1 and credit=0 -> no-op. A coin in the same cycle is processed normally.
  - Valid coin with credit+value <= MAX_UNITS -> credit <= credit+value. If the new credit >= PRICE_UNITS, next state is VEND; otherwise stay in ACCEPT.
  - Valid coin with credit+value > MAX_UNITS -> rejected; credit unchanged.
  - Invalid code -> rejected; credit unchanged.
  - coin=000 -> hold.
- VEND: exactly one cycle.
  - dispense=1.
  - credit <= credit-PRICE_UNITS.
  - Next state is CHANGE if the remainder > 0, else ACCEPT.
- CHANGE / REFUND:
  - Each cycle: change_quarter=1 and credit <= credit-1.
  - When credit==1 in that cycle, next state is ACCEPT.
  - Result: exactly N consecutive pulses for N units held on entry.
  - refunding=1 only in REFUND.
- Busy states (VEND, CHANGE, REFUND):
  - Any nonzero coin is rejected.
  - cancel is ignored.
- Rejection:
  - error=1 on the cycle following the rejected coin cycle, for one cycle.
  - Back-to-back rejections give back-to-back error pulses.
- Arithmetic:
  - Addition is computed at CW+1 bits so the overflow compare cannot wrap.
  - credit never exceeds MAX_UNITS and never underflows.
- Latency:
  - Coin to credit update: 1 cycle.
  - Price-reaching coin to dispense: 1 cycle.
  - First change pulse: the cycle after dispense.

Test Plan:
- Defaults; dollar then quarter -> credit 4, then 5. Next cycle dispense=1 and credit=0, then ACCEPT with no change_quarter pulses.
- Defaults; dollar, dollar -> credit 8. VEND: dispense=1, credit 3. Then 3 consecutive change_quarter pulses with credit 2, 1, 0; busy low after the third pulse.
- Defaults; fifty, quarter, cancel -> credit 3, then REFUND: 3 change_quarter pulses with refunding=1, dispense never asserted, credit ends 0.
- PRICE_UNITS=12, MAX_UNITS=12; dollar, dollar, fifty (credit 10), then dollar -> error pulse the next cycle, credit stays 10. Then fifty -> credit 12, dispense, no change pulses.
- Defaults; coin=011 in ACCEPT -> error pulse, credit unchanged. Coin=001 during CHANGE -> error pulse, change sequence unaffected. cancel=1 with a quarter in the same cycle at credit 2 -> REFUND, error pulse.
- Defaults; dollar, dollar, then assert reset after the first change pulse -> immediately ACCEPT, credit=0, all outputs 0, no further change pulses.

Source files
------------

// File: rtl/vend_change_fsm_if.sv
// ============================================================================
// Module      : vend_change_fsm_if
// Description : Coin/cancel inputs and credit/actuator outputs of the vending
//               change controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vend_change_fsm_if #(
    parameter int CW = 4
);
    logic [2:0]    coin;
    logic          cancel;
    logic [CW-1:0] credit;
    logic          busy;
    logic          dispense;
    logic          change_quarter;
    logic          refunding;
    logic          error;

    modport master (
        output coin, cancel,
        input  credit, busy, dispense, change_quarter, refunding, error
    );

    modport slave (
        input  coin, cancel,
        output credit, busy, dispense, change_quarter, refunding, error
    );
endinterface

`default_nettype wire

// File: rtl/vend_change_fsm.sv
// ============================================================================
// Module      : vend_change_fsm
// Description : Parametrised vending controller with binary credit counter,
//               change return and cancel/refund sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_change_fsm #(
    parameter int PRICE_UNITS = 5,
    parameter int MAX_UNITS   = 12,
    localparam int CW         = $clog2(MAX_UNITS + 1)
) (
    input  wire               clk,
    input  wire               reset,
    vend_change_fsm_if.slave  bus
);

    // Sum width is at least CW+1 and always wide enough to hold a dollar code.
    localparam int SW = (CW >= 3) ? CW + 1 : 4;

    localparam logic [SW-1:0] c_MAX_S   = SW'(MAX_UNITS);
    localparam logic [SW-1:0] c_PRICE_S = SW'(PRICE_UNITS);
    localparam logic [CW-1:0] c_PRICE_C = CW'(PRICE_UNITS);
    localparam logic [CW-1:0] c_ONE     = CW'(1);
    localparam logic [CW-1:0] c_ZERO    = '0;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2,
        REFUND = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_credit_nxt;
    logic          r_error;
    logic          w_reject;

    logic [SW-1:0] w_value;
    logic          w_coin_valid;
    logic          w_coin_any;
    logic [SW-1:0] w_sum;
    logic [CW-1:0] w_remain;

    always_comb begin
        w_value      = '0;
        w_coin_valid = 1'b1;
        unique case (bus.coin)
            3'b000:  w_value = '0;
            3'b001:  w_value = SW'(1);
            3'b010:  w_value = SW'(2);
            3'b100:  w_value = SW'(4);
            default: w_coin_valid = 1'b0;
        endcase
    end

    assign w_coin_any = (bus.coin != 3'b000);
    assign w_sum      = {{(SW-CW){1'b0}}, r_credit} + w_value;
    assign w_remain   = r_credit - c_PRICE_C;

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_reject     = 1'b0;
        unique case (r_state)
            ACCEPT: begin
                if (bus.cancel && (r_credit != c_ZERO)) begin
                    // Cancel wins over a simultaneous coin.
                    w_state_nxt = REFUND;
                    w_reject    = w_coin_any;
                end else if (w_coin_any) begin
                    if (!w_coin_valid || (w_sum > c_MAX_S)) begin
                        w_reject = 1'b1;
                    end else begin
                        w_credit_nxt = w_sum[CW-1:0];
                        if (w_sum >= c_PRICE_S) begin
                            w_state_nxt = VEND;
                        end
                    end
                end
            end
            VEND: begin
                w_reject     = w_coin_any;
                w_credit_nxt = w_remain;
                w_state_nxt  = (w_remain != c_ZERO) ? CHANGE : ACCEPT;
            end
            CHANGE, REFUND: begin
                w_reject = w_coin_any;
                if (r_credit <= c_ONE) begin
                    w_credit_nxt = c_ZERO;
                    w_state_nxt  = ACCEPT;
                end else begin
                    w_credit_nxt = r_credit - c_ONE;
                end
            end
            default: w_state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ACCEPT;
            r_credit <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_error  <= w_reject;
        end
    end

    assign bus.credit         = r_credit;
    assign bus.busy           = (r_state != ACCEPT);
    assign bus.dispense       = (r_state == VEND);
    assign bus.change_quarter = (r_state == CHANGE) || (r_state == REFUND);
    assign bus.refunding      = (r_state == REFUND);
    assign bus.error          = r_error;

endmodule

`default_nettype wire

// File: tb/tb_vend_change_fsm.sv
// ============================================================================
// Module      : tb_vend_change_fsm
// Description : Directed self-checking bench for vend_change_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_change_fsm;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    vend_change_fsm_if #(.CW(4)) bus_a ();
    vend_change_fsm_if #(.CW(4)) bus_b ();

    vend_change_fsm #(.PRICE_UNITS(5), .MAX_UNITS(12)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    vend_change_fsm #(.PRICE_UNITS(12), .MAX_UNITS(12)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snapshot of DUT A outputs: credit, dispense, change_quarter, refunding, busy, error.
    task automatic chk_a(input string tag, input int cr, input bit d, input bit cq,
                         input bit rf, input bit bz, input bit er);
        chk({tag, ".credit"},   16'(bus_a.credit),         16'(cr));
        chk({tag, ".dispense"}, 16'(bus_a.dispense),       16'(d));
        chk({tag, ".cq"},       16'(bus_a.change_quarter), 16'(cq));
        chk({tag, ".refund"},   16'(bus_a.refunding),      16'(rf));
        chk({tag, ".busy"},     16'(bus_a.busy),           16'(bz));
        chk({tag, ".error"},    16'(bus_a.error),          16'(er));
    endtask

    task automatic chk_b(input string tag, input int cr, input bit d, input bit cq,
                         input bit bz, input bit er);
        chk({tag, ".credit"},   16'(bus_b.credit),         16'(cr));
        chk({tag, ".dispense"}, 16'(bus_b.dispense),       16'(d));
        chk({tag, ".cq"},       16'(bus_b.change_quarter), 16'(cq));
        chk({tag, ".busy"},     16'(bus_b.busy),           16'(bz));
        chk({tag, ".error"},    16'(bus_b.error),          16'(er));
    endtask

    task automatic coin_a(input logic [2:0] c, input logic can);
        bus_a.coin   = c;
        bus_a.cancel = can;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        bus_a.coin   = 3'b000;
        bus_a.cancel = 1'b0;
        bus_b.coin   = 3'b000;
        bus_b.cancel = 1'b0;
        tick();
        tick();
        chk_a("rst_a", 0, 0, 0, 0, 0, 0);
        chk_b("rst_b", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Exact price: dollar + quarter, no change.
        coin_a(3'b100, 0); tick(); chk_a("t1_d",    4, 0, 0, 0, 0, 0);
        coin_a(3'b001, 0); tick(); chk_a("t1_q",    5, 1, 0, 0, 1, 0);
        coin_a(3'b000, 0); tick(); chk_a("t1_done", 0, 0, 0, 0, 0, 0);
        tick();                    chk_a("t1_idle", 0, 0, 0, 0, 0, 0);

        // Two dollars: vend then three change quarters.
        coin_a(3'b100, 0); tick(); chk_a("t2_d1",   4, 0, 0, 0, 0, 0);
        coin_a(3'b100, 0); tick(); chk_a("t2_vend", 8, 1, 0, 0, 1, 0);
        coin_a(3'b000, 0); tick(); chk_a("t2_c1",   3, 0, 1, 0, 1, 0);
        tick();                    chk_a("t2_c2",   2, 0, 1, 0, 1, 0);
        tick();                    chk_a("t2_c3",   1, 0, 1, 0, 1, 0);
        tick();                    chk_a("t2_end",  0, 0, 0, 0, 0, 0);

        // Fifty + quarter, then cancel: three refund quarters, no dispense.
        coin_a(3'b010, 0); tick(); chk_a("t3_f",    2, 0, 0, 0, 0, 0);
        coin_a(3'b001, 0); tick(); chk_a("t3_q",    3, 0, 0, 0, 0, 0);
        coin_a(3'b000, 1); tick(); chk_a("t3_r1",   3, 0, 1, 1, 1, 0);
        coin_a(3'b000, 0); tick(); chk_a("t3_r2",   2, 0, 1, 1, 1, 0);
        tick();                    chk_a("t3_r3",   1, 0, 1, 1, 1, 0);
        tick();                    chk_a("t3_end",  0, 0, 0, 0, 0, 0);

        // Cancel with zero credit is a no-op; a coin alongside it is taken.
        coin_a(3'b001, 1); tick(); chk_a("t3_c0",   1, 0, 0, 0, 0, 0);
        coin_a(3'b000, 1); tick(); chk_a("t3_c0r",  1, 0, 1, 1, 1, 0);
        coin_a(3'b000, 0); tick(); chk_a("t3_c0e",  0, 0, 0, 0, 0, 0);

        // Invalid code rejected; back-to-back rejects give back-to-back errors.
        coin_a(3'b011, 0); tick(); chk_a("t5_inv",  0, 0, 0, 0, 0, 1);
        coin_a(3'b110, 0); tick(); chk_a("t5_bb1",  0, 0, 0, 0, 0, 1);
        coin_a(3'b111, 0); tick(); chk_a("t5_bb2",  0, 0, 0, 0, 0, 1);
        coin_a(3'b000, 0); tick(); chk_a("t5_clr",  0, 0, 0, 0, 0, 0);

        // Quarter during change is rejected without disturbing the sequence.
        coin_a(3'b100, 0); tick(); chk_a("t5_d1",   4, 0, 0, 0, 0, 0);
        coin_a(3'b100, 0); tick(); chk_a("t5_v",    8, 1, 0, 0, 1, 0);
        coin_a(3'b000, 0); tick(); chk_a("t5_c1",   3, 0, 1, 0, 1, 0);
        coin_a(3'b001, 1); tick(); chk_a("t5_c2",   2, 0, 1, 0, 1, 1);
        coin_a(3'b000, 0); tick(); chk_a("t5_c3",   1, 0, 1, 0, 1, 0);
        tick();                    chk_a("t5_cend", 0, 0, 0, 0, 0, 0);

        // Cancel with a simultaneous quarter at credit 2: refund wins, coin rejected.
        coin_a(3'b010, 0); tick(); chk_a("t5_f",    2, 0, 0, 0, 0, 0);
        coin_a(3'b001, 1); tick(); chk_a("t5_r1",   2, 0, 1, 1, 1, 1);
        coin_a(3'b000, 0); tick(); chk_a("t5_r2",   1, 0, 1, 1, 1, 0);
        tick();                    chk_a("t5_rend", 0, 0, 0, 0, 0, 0);

        // Overflow at MAX with PRICE == MAX on the second instance.
        bus_b.coin = 3'b100; tick(); chk_b("t4_d1",   4, 0, 0, 0, 0);
        bus_b.coin = 3'b100; tick(); chk_b("t4_d2",   8, 0, 0, 0, 0);
        bus_b.coin = 3'b010; tick(); chk_b("t4_f",   10, 0, 0, 0, 0);
        bus_b.coin = 3'b100; tick(); chk_b("t4_ovf", 10, 0, 0, 0, 1);
        bus_b.coin = 3'b010; tick(); chk_b("t4_max", 12, 1, 0, 1, 0);
        bus_b.coin = 3'b000; tick(); chk_b("t4_end",  0, 0, 0, 0, 0);
        tick();                      chk_b("t4_idle", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a change sequence.
        coin_a(3'b100, 0); tick(); chk_a("t6_d1",   4, 0, 0, 0, 0, 0);
        coin_a(3'b100, 0); tick(); chk_a("t6_v",    8, 1, 0, 0, 1, 0);
        coin_a(3'b000, 0); tick(); chk_a("t6_c1",   3, 0, 1, 0, 1, 0);
        tick();                    chk_a("t6_c2",   2, 0, 1, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_a("t6_async", 0, 0, 0, 0, 0, 0);
        tick();                    chk_a("t6_hold", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();                    chk_a("t6_rel1", 0, 0, 0, 0, 0, 0);
        tick();                    chk_a("t6_rel2", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
